systolic_mac_array: RTL and testbench
=====================================

# systolic_mac_array

Parametrised successor to the fixed 8-lane MAC array: LANES multiply-accumulate lanes share one B operand stream that is skewed one lane per cycle, while each lane consumes its own A stream. It adds a run/flush/drain controller, signed/unsigned mode and per-lane underrun flags, and returns results over a serial valid/ready port. It sits between the per-lane A FIFOs and the B FIFO on the input side and the result writer on the output side.

## Interface
- LANES, 8, number of MAC lanes (≥2)
- DATA_W, 8, A/B operand width
- ACC_W, 24, accumulator width (must be ≥ 2*DATA_W)

- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE
- signed_mode  in  1  operand signedness, sampled on an accepted start
- b_valid  in  1  B token valid
- b_ready  out  1  B token accepted when b_valid && b_ready
- b_in  in  DATA_W  B operand
- b_last  in  1  marks the final B token of the run
- a_valid  in  LANES  per-lane A available (FIFO not empty)
- a_ready  out  LANES  lane i consumes A this cycle (FIFO pop)
- a_in  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  ACC_W  accumulator of lane res_lane
- res_lane  out  $clog2(LANES)  lane index of res_data
- underrun  out  LANES  sticky: lane i skipped a term because a_valid[i] was low
- busy  out  1  state != IDLE

## Operation
- FSM states are IDLE, RUN, FLUSH and DRAIN.
- IDLE → RUN on start. This clears every accumulator and underrun, and latches signed_mode.
- start is ignored in every state other than IDLE.
- RUN: b_ready=1. An accepted token enters B stage 0. Stage k advances to stage k+1 each cycle with its valid and last bits.
- RUN → FLUSH when a token is accepted with b_last=1.
- FLUSH: b_ready=0. FLUSH → DRAIN in the cycle the last-flagged token occupies stage LANES-1, once that lane's accumulate is committed.
- Lane i, when stage i is valid:
  - a_ready[i]=1, combinational from the stage register.
  - If a_valid[i]=1, then acc[i] += ext(a_i × b_i).
  - If a_valid[i]=0, the term is skipped and underrun[i] is set.
- DRAIN: lanes are presented in order 0..LANES-1. res_lane advances only on res_valid && res_ready.
- res_data and res_lane stay stable while res_valid && !res_ready.
- DRAIN → IDLE on the handshake of lane LANES-1.
- Arithmetic:
  - The product is a full 2*DATA_W result, signed or unsigned per the latched mode.
  - It is sign- or zero-extended to ACC_W before the add.
  - Overflow behaviour is set under Configuration.
- Accumulators and underrun hold their values after DRAIN until the next accepted start.
- rst at any time, including mid-RUN or mid-DRAIN:
  - FSM goes to IDLE.
  - All pipeline valids, accumulators and underrun are cleared.
  - No partial result is emitted.

## Timing
- Reset values: b_ready=0, a_ready=0, res_valid=0, res_data=0, res_lane=0, underrun=0, busy=0.
- start sampled in cycle s: busy=1 and b_ready=1 from cycle s+1.
- Token accepted in cycle t: a_ready[i]=1 in cycle t+1+i. acc[i] is updated at the end of that cycle.
- Last token accepted in cycle t: FLUSH occupies cycles t+1..t+LANES. res_valid is first high in cycle t+LANES+1.
- Drain throughput is 1 lane per cycle with res_ready held high. A full drain takes LANES cycles minimum.
- Back-to-back B tokens give one MAC per lane per cycle with no bubbles.

## Configuration
- MAC_ARRAY_SAT_EN defined: accumulate saturates at the mode's ACC_W limits.
  - Unsigned: 2^ACC_W−1.
  - Signed: 2^(ACC_W−1)−1 and −2^(ACC_W−1).
  - Once saturated, an accumulator stays at the limit until the opposite-sign terms bring it back in range.
- MAC_ARRAY_SAT_EN undefined: accumulate wraps modulo 2^ACC_W.

## Test plan
- Unsigned mode, defaults, all a_in=2 with a_valid all high; B stream 1, 2, 3 (last) on consecutive cycles → res_valid first asserts 9 cycles after the last accept; lanes 0..7 each return 12; underrun=0.
- Signed mode, a_in=0xFD (−3) on all lanes; B stream 5, 0xFE (−2, last) → every lane returns 0xFFFFF7 (−9).
- a_valid[3]=0 only in the cycle token 2 reaches lane 3; B stream 1, 2, 3 with all a=2 → lane 3 returns 8, other lanes return 12, underrun=0x08.
- res_ready held low for 5 cycles while res_lane=2 → res_data and res_lane are stable throughout, no lane is skipped, and DRAIN completes with 8 handshakes.
- DATA_W=8, ACC_W=16, unsigned, a=0xFF, B stream 0xFF, 0xFF (last) → 0xFFFF with MAC_ARRAY_SAT_EN defined; 0xFC02 without it.
- rst pulsed mid-DRAIN at lane 4 → all outputs return to their reset values the same cycle; a new start then runs a full run correctly, with no stale data.

Source files
------------

// File: rtl/systolic_mac_array.sv
// ============================================================================
// Module  : systolic_mac_array
// Brief   : LANES MAC lanes fed by one skewed B stream, drained serially.
//           Optional saturation: define MAC_ARRAY_SAT_EN (default wraps).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_mac_array #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_signed_mode,
  input  logic                      i_b_valid,
  output logic                      o_b_ready,
  input  logic [DATA_W-1:0]         i_b_in,
  input  logic                      i_b_last,
  input  logic [LANES-1:0]          i_a_valid,
  output logic [LANES-1:0]          o_a_ready,
  input  logic [LANES*DATA_W-1:0]   i_a_in,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [ACC_W-1:0]          o_res_data,
  output logic [$clog2(LANES)-1:0]  o_res_lane,
  output logic [LANES-1:0]          o_underrun,
  output logic                      o_busy
);

  localparam int                LANE_W      = $clog2(LANES);
  localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t                 r_state;
  logic                   r_signed;
  logic [DATA_W-1:0]      r_b_data [LANES];
  logic [LANES-1:0]       r_b_vld;
  logic [LANES-1:0]       r_b_last;
  logic [ACC_W-1:0]       r_acc [LANES];
  logic [LANES-1:0]       r_underrun;
  logic [LANE_W-1:0]      r_lane;
  logic [LANES*ACC_W-1:0] w_acc_next;
  logic                   w_b_accept;

  assign o_b_ready   = (r_state == S_RUN);
  assign w_b_accept  = o_b_ready && i_b_valid;
  assign o_a_ready   = r_b_vld;
  assign o_busy      = (r_state != S_IDLE);
  assign o_res_valid = (r_state == S_DRAIN);
  assign o_res_lane  = r_lane;
  assign o_res_data  = o_res_valid ? r_acc[r_lane] : '0;
  assign o_underrun  = r_underrun;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0]   w_a;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_term;
    logic [ACC_W:0]      w_sum;

    assign w_a     = i_a_in[gi*DATA_W +: DATA_W];
    // Extending operands to 2*DATA_W first makes the low half of a plain
    // multiply correct for both signed and unsigned operands.
    assign w_a_ext = {{DATA_W{r_signed & w_a[DATA_W-1]}}, w_a};
    assign w_b_ext = {{DATA_W{r_signed & r_b_data[gi][DATA_W-1]}}, r_b_data[gi]};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_term  = {{(ACC_W+1-2*DATA_W){r_signed & w_prod[2*DATA_W-1]}}, w_prod};
    assign w_sum   = {r_signed & r_acc[gi][ACC_W-1], r_acc[gi]} + w_term;

`ifdef MAC_ARRAY_SAT_EN
    logic             w_ovf;
    logic [ACC_W-1:0] w_limit;

    assign w_ovf   = r_signed ? (w_sum[ACC_W] != w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_limit = !r_signed     ? {ACC_W{1'b1}} :
                     w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};
    assign w_acc_next[gi*ACC_W +: ACC_W] = w_ovf ? w_limit : w_sum[ACC_W-1:0];
`else
    assign w_acc_next[gi*ACC_W +: ACC_W] = w_sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_signed   <= 1'b0;
      r_b_vld    <= '0;
      r_b_last   <= '0;
      r_underrun <= '0;
      r_lane     <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_b_data[i] <= '0;
        r_acc[i]    <= '0;
      end
    end else begin
      r_b_vld     <= {r_b_vld[LANES-2:0], w_b_accept};
      r_b_last    <= {r_b_last[LANES-2:0], w_b_accept & i_b_last};
      r_b_data[0] <= i_b_in;
      for (int i = 1; i < LANES; i++) r_b_data[i] <= r_b_data[i-1];

      for (int i = 0; i < LANES; i++) begin
        if (r_b_vld[i]) begin
          if (i_a_valid[i]) r_acc[i] <= w_acc_next[i*ACC_W +: ACC_W];
          else              r_underrun[i] <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_RUN;
            r_signed   <= i_signed_mode;
            r_underrun <= '0;
            r_lane     <= '0;
            for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
          end
        end
        S_RUN: begin
          if (w_b_accept && i_b_last) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          // The last token's accumulate into lane LANES-1 lands this same edge.
          if (r_b_vld[LANES-1] && r_b_last[LANES-1]) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (i_res_ready) begin
            if (r_lane == c_LAST_LANE) begin
              r_state <= S_IDLE;
              r_lane  <= '0;
            end else begin
              r_lane <= r_lane + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_mac_array.sv
// ============================================================================
// Module  : tb_systolic_mac_array
// Brief   : Directed self-checking bench for systolic_mac_array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_mac_array;
  localparam int LANES  = 8;
  localparam int DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    signed_mode = 1'b0;
  logic                    b_valid = 1'b0;
  logic [DATA_W-1:0]       b_in = '0;
  logic                    b_last = 1'b0;
  logic [LANES-1:0]        a_valid = '1;
  logic [LANES*DATA_W-1:0] a_in = '0;
  logic                    res_ready = 1'b1;

  logic                    b_ready, res_valid, busy;
  logic [LANES-1:0]        a_ready, underrun;
  logic [23:0]             res_data;
  logic [2:0]              res_lane;

  logic                    b_ready2, res_valid2, busy2;
  logic [LANES-1:0]        a_ready2, underrun2;
  logic [15:0]             res_data2;
  logic [2:0]              res_lane2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_d  [LANES];
  logic [31:0] exp_d2 [LANES];
  int cyc;

  always #5 clk = ~clk;

  systolic_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(24)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_signed_mode(signed_mode),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_in(b_in), .i_b_last(b_last),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_in(a_in),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_res_lane(res_lane), .o_underrun(underrun), .o_busy(busy)
  );

  systolic_mac_array #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .i_start(start), .i_signed_mode(signed_mode),
    .i_b_valid(b_valid), .o_b_ready(b_ready2), .i_b_in(b_in), .i_b_last(b_last),
    .i_a_valid(a_valid), .o_a_ready(a_ready2), .i_a_in(a_in),
    .o_res_valid(res_valid2), .i_res_ready(res_ready), .o_res_data(res_data2),
    .o_res_lane(res_lane2), .o_underrun(underrun2), .o_busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_all(input logic [DATA_W-1:0] v);
    for (int i = 0; i < LANES; i++) a_in[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_start(input logic mode);
    start = 1'b1;
    signed_mode = mode;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("b_ready_after_start", {31'd0, b_ready}, 32'd1);
  endtask

  task automatic send(input logic [DATA_W-1:0] b, input logic last);
    b_valid = 1'b1;
    b_in    = b;
    b_last  = last;
    tick();
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  // Called in the cycle after the last accept; returns cycles-since-accept.
  task automatic wait_res(output int c);
    c = 1;
    while (!res_valid && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic drain(input bit check16);
    res_ready = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      chk("drain_valid", {31'd0, res_valid}, 32'd1);
      chk("drain_lane", {29'd0, res_lane}, l);
      chk("drain_data", {8'd0, res_data}, exp_d[l]);
      if (check16) chk("drain_data16", {16'd0, res_data2}, exp_d2[l]);
      tick();
    end
    chk("busy_after_drain", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_a_ready", {24'd0, a_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {8'd0, res_data}, 32'd0);
    chk("rst_res_lane", {29'd0, res_lane}, 32'd0);
    chk("rst_underrun", {24'd0, underrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: unsigned, a=2, B = 1,2,3 -> 12 per lane, 9-cycle latency
    set_a_all(8'd2);
    do_start(1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    chk("flush_b_ready", {31'd0, b_ready}, 32'd0);
    wait_res(cyc);
    chk("t1_latency", cyc, 32'd9);
    for (int l = 0; l < LANES; l++) exp_d[l] = 32'd12;
    drain(1'b0);
    chk("t1_underrun", {24'd0, underrun}, 32'd0);

    // T2: signed, a=-3, B = 5,-2 -> -9; start held high mid-run must be ignored
    set_a_all(8'hFD);
    do_start(1'b1);
    start = 1'b1;
    signed_mode = 1'b0;
    send(8'd5, 1'b0);
    send(8'hFE, 1'b1);
    start = 1'b0;
    wait_res(cyc);
    chk("t2_latency", cyc, 32'd9);
    for (int l = 0; l < LANES; l++) exp_d[l] = 32'hFFFFF7;
    drain(1'b0);

    // T3: lane 3 misses token 2 -> 8 on lane 3, underrun=0x08
    set_a_all(8'd2);
    do_start(1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    tick();
    tick();
    chk("t3_a_ready3", {31'd0, a_ready[3]}, 32'd1);
    a_valid[3] = 1'b0;
    tick();
    a_valid[3] = 1'b1;
    wait_res(cyc);
    chk("t3_res_valid", {31'd0, res_valid}, 32'd1);
    for (int l = 0; l < LANES; l++) exp_d[l] = (l == 3) ? 32'd8 : 32'd12;
    drain(1'b0);
    chk("t3_underrun_held", {24'd0, underrun}, 32'h08);

    // T4: a lane i = i+1, B = 1,2,3 -> 6*(i+1); stall 5 cycles at lane 2
    for (int i = 0; i < LANES; i++) a_in[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    do_start(1'b0);
    chk("t4_underrun_cleared", {24'd0, underrun}, 32'd0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    wait_res(cyc);
    chk("t4_res_valid", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    tick();
    tick();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_lane", {29'd0, res_lane}, 32'd2);
      chk("t4_stall_data", {8'd0, res_data}, 32'd18);
      tick();
    end
    res_ready = 1'b1;
    cyc = 2;
    for (int l = 2; l < LANES; l++) begin
      chk("t4_lane", {29'd0, res_lane}, l);
      chk("t4_data", {8'd0, res_data}, 32'(6 * (l + 1)));
      if (res_valid) cyc++;
      tick();
    end
    chk("t4_handshakes", cyc, 32'd8);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // T5: a=0xFF, B = 0xFF,0xFF unsigned; 16-bit instance saturates or wraps
    set_a_all(8'hFF);
    do_start(1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    wait_res(cyc);
    chk("t5_latency", cyc, 32'd9);
    for (int l = 0; l < LANES; l++) begin
      exp_d[l] = 32'h01FC02;
`ifdef MAC_ARRAY_SAT_EN
      exp_d2[l] = 32'hFFFF;
`else
      exp_d2[l] = 32'hFC02;
`endif
    end
    drain(1'b1);

    // T6: reset mid-DRAIN at lane 4, then a clean full run
    set_a_all(8'hFD);
    do_start(1'b1);
    send(8'd5, 1'b0);
    send(8'hFE, 1'b1);
    wait_res(cyc);
    res_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      chk("t6_pre_data", {8'd0, res_data}, 32'hFFFFF7);
      tick();
    end
    chk("t6_at_lane4", {29'd0, res_lane}, 32'd4);
    rst = 1'b1;
    #1;
    chk("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t6_rst_res_data", {8'd0, res_data}, 32'd0);
    chk("t6_rst_res_lane", {29'd0, res_lane}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("t6_rst_a_ready", {24'd0, a_ready}, 32'd0);
    chk("t6_rst_underrun", {24'd0, underrun}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    set_a_all(8'd2);
    do_start(1'b0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    wait_res(cyc);
    chk("t6_latency", cyc, 32'd9);
    for (int l = 0; l < LANES; l++) exp_d[l] = 32'd12;
    drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
